// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB types and widths for the two-requester APB master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_rr_arb.sv
// ============================================================================
// Module      : apb_rr_arb
// Description : Two-way round-robin arbiter; one-hot grant from request vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_rr_arb (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // On contention the requester that did not win last time goes first
            2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/apb_master_arb.sv
// ============================================================================
// Module      : apb_master_arb
// Description : APB master shared by two requesters with round-robin grant
//               and an ACCESS-phase wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arb
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [1:0]                 req_valid,
    input  logic [1:0]                 req_write,
    input  logic [1:0][APB_ADDR_W-1:0] req_addr,
    input  logic [1:0][APB_DATA_W-1:0] req_wdata,
    output logic [1:0]                 req_done,
    output logic [1:0]                 req_err,
    output logic [APB_DATA_W-1:0]      req_rdata,
    output logic                       psel,
    output logic                       penable,
    output logic                       pwrite,
    output logic [APB_ADDR_W-1:0]      paddr,
    output logic [APB_DATA_W-1:0]      pwdata,
    input  logic                       pready,
    input  logic                       pslverr,
    input  logic [APB_DATA_W-1:0]      prdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e            state_q;
    logic                  psel_q, penable_q, pwrite_q;
    logic [APB_ADDR_W-1:0] paddr_q;
    logic [APB_DATA_W-1:0] pwdata_q, rdata_q;
    logic [1:0]            done_q, err_q;
    logic                  gnt_q, last_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            gnt_oh;
    logic                  win_d;

    apb_rr_arb u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (gnt_oh)
    );

    assign win_d = gnt_oh[1] & ~gnt_oh[0];

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        state_q  <= SETUP;
                        psel_q   <= 1'b1;
                        gnt_q    <= win_d;
                        pwrite_q <= req_write[win_d];
                        paddr_q  <= req_addr[win_d];
                        pwdata_q <= req_wdata[win_d];
                        cnt_q    <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        state_q        <= IDLE;
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        done_q[gnt_q]  <= 1'b1;
                        err_q[gnt_q]   <= pslverr;
                        last_q         <= gnt_q;
                        if (!pwrite_q) begin
                            rdata_q <= prdata;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Slave never answered: fail the transfer, keep rdata
                        state_q        <= IDLE;
                        psel_q         <= 1'b0;
                        penable_q      <= 1'b0;
                        done_q[gnt_q]  <= 1'b1;
                        err_q[gnt_q]   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign req_done  = done_q;
    assign req_err   = err_q;
    assign req_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arb.sv
// ============================================================================
// Module      : tb_apb_master_arb
// Description : Scoreboard bench for apb_master_arb with a transaction-level
//               arbitration/timeout reference model and a planned APB slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arb;

    localparam int TIMEOUT = 16;

    typedef struct {
        bit        wr;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        waits;
        bit        slverr;
        bit [31:0] prdata;
    } xfer_t;

    typedef struct {
        bit        idx;
        bit        wr;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit        err;
        bit [31:0] rdata;
        int        acc;
    } exp_t;

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_write = '0;
    logic [1:0][31:0]  req_addr = '0;
    logic [1:0][31:0]  req_wdata = '0;
    logic [1:0]        req_done, req_err;
    logic [31:0]       req_rdata;
    logic              psel, penable, pwrite;
    logic [31:0]       paddr, pwdata;
    logic              pready = 1'b0;
    logic              pslverr = 1'b0;
    logic [31:0]       prdata = '0;

    apb_master_arb #(.TIMEOUT(TIMEOUT)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_err   (req_err),
        .req_rdata (req_rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .prdata    (prdata)
    );

    always #5 pclk = ~pclk;

    int    n_chk  = 0;
    int    n_pass = 0;
    xfer_t pend0[$];
    xfer_t pend1[$];
    exp_t  exp_q[$];
    xfer_t plan_q[$];
    bit        last_m  = 1'b1;
    bit [31:0] rdata_m = '0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    endtask

    // Transaction-level reference: order of service and outcome of each pending transfer
    task automatic build_expected();
        xfer_t q0[$];
        xfer_t q1[$];
        xfer_t x;
        exp_t  e;
        bit    pick, tmo;
        q0 = pend0;
        q1 = pend1;
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) pick = ~last_m;
            else pick = (q1.size() > 0);
            x = pick ? q1.pop_front() : q0.pop_front();
            tmo = (x.waits >= TIMEOUT);
            e.idx = pick; e.wr = x.wr; e.addr = x.addr; e.wdata = x.wdata;
            e.err = tmo ? 1'b1 : x.slverr;
            if (!tmo && !x.wr) rdata_m = x.prdata;
            e.rdata = rdata_m;
            e.acc = tmo ? TIMEOUT : x.waits + 1;
            if (!tmo) last_m = pick;
            exp_q.push_back(e);
            plan_q.push_back(x);
        end
    endtask

    task automatic present();
        req_valid = '0;
        if (pend0.size() > 0) begin
            req_valid[0] = 1'b1; req_write[0] = pend0[0].wr;
            req_addr[0] = pend0[0].addr; req_wdata[0] = pend0[0].wdata;
        end
        if (pend1.size() > 0) begin
            req_valid[1] = 1'b1; req_write[1] = pend1[0].wr;
            req_addr[1] = pend1[0].addr; req_wdata[1] = pend1[0].wdata;
        end
    endtask

    task automatic run_batch();
        int cyc;
        build_expected();
        @(negedge pclk);
        present();
        cyc = 0;
        while ((pend0.size() + pend1.size()) > 0 && cyc < 2000) begin
            @(negedge pclk);
            cyc++;
            if (cyc == 1) chk(psel && !penable, "first_setup_latency", {psel, penable}, 2'b10);
            if (req_done[0] && pend0.size() > 0) void'(pend0.pop_front());
            if (req_done[1] && pend1.size() > 0) void'(pend1.pop_front());
            present();
        end
        if (cyc >= 2000) chk(1'b0, "batch_timeout", cyc, 2000);
        @(negedge pclk);
        chk(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
    endtask

    function automatic xfer_t mk(bit wr, bit [31:0] addr, bit [31:0] wd, int waits, bit se, bit [31:0] rd);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.wdata = wd; x.waits = waits; x.slverr = se; x.prdata = rd;
        return x;
    endfunction

    function automatic xfer_t rnd();
        int r;
        r = $urandom_range(0, 19);
        return mk(1'($urandom_range(0, 1)), $urandom, $urandom,
                  (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0), $urandom);
    endfunction

    // APB slave: follows the planned wait count of the transfer it is serving
    xfer_t s_cur;
    int    s_acc;
    initial begin
        s_cur = mk(0, 0, 0, 0, 0, 0);
        s_acc = 0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                pready = 1'b0;
            end else if (psel && !penable) begin
                if (plan_q.size() > 0) s_cur = plan_q.pop_front();
                s_acc = 0;
                pready = 1'b0;
                pslverr = s_cur.slverr;
                prdata = s_cur.prdata;
            end else if (psel && penable) begin
                s_acc++;
                pready = (s_acc > s_cur.waits);
            end else begin
                pready = 1'b0;
            end
        end
    end

    // Monitor: compares every APB setup and every completion against the scoreboard
    exp_t        m_e;
    int          m_acc;
    bit          m_prev_done, m_expect_setup, m_wr;
    logic [31:0] m_addr, m_wd;
    initial begin
        m_acc = 0; m_prev_done = 0; m_expect_setup = 0; m_wr = 0; m_addr = '0; m_wd = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                m_acc = 0; m_prev_done = 0; m_expect_setup = 0;
                m_wr = 0; m_addr = '0; m_wd = '0;
            end else begin
                if (m_expect_setup)
                    chk(psel && !penable, "b2b_spacing", {psel, penable}, 2'b10);
                m_expect_setup = 0;
                if (m_prev_done)
                    chk(req_done == 2'b00, "done_one_cycle", req_done, 0);
                if (psel && !penable) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_setup", paddr, 0);
                    end else begin
                        chk(paddr == exp_q[0].addr, "setup_paddr", paddr, exp_q[0].addr);
                        chk({pwrite, pwdata} == {exp_q[0].wr, exp_q[0].wdata}, "setup_pwrite_pwdata",
                            {pwrite, pwdata}, {exp_q[0].wr, exp_q[0].wdata});
                    end
                    m_acc = 0; m_addr = paddr; m_wd = pwdata; m_wr = pwrite;
                end else if (psel && penable) begin
                    m_acc++;
                    chk({pwrite, paddr, pwdata} == {m_wr, m_addr, m_wd}, "access_stable",
                        {pwrite, paddr}, {m_wr, m_addr});
                end else begin
                    chk({pwrite, paddr, pwdata} == {m_wr, m_addr, m_wd}, "idle_hold",
                        {pwrite, paddr}, {m_wr, m_addr});
                end
                m_prev_done = (req_done != 2'b00);
                if (req_done != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_done", req_done, 0);
                    end else begin
                        m_e = exp_q.pop_front();
                        chk(req_done == (2'b01 << m_e.idx), "done_grant", req_done, 2'b01 << m_e.idx);
                        chk(req_err == (2'(m_e.err) << m_e.idx), "err", req_err, 2'(m_e.err) << m_e.idx);
                        chk(req_rdata == m_e.rdata, "rdata", req_rdata, m_e.rdata);
                        chk(m_acc == m_e.acc, "access_cycles", m_acc, m_e.acc);
                        chk(!psel, "idle_after_done", psel, 0);
                        m_expect_setup = (exp_q.size() > 0);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: actual=%0t required=finish", $time);
        $fatal(1, "bench stalled");
    end

    initial begin
        int w;
        repeat (2) @(negedge pclk);
        chk({psel, penable, pwrite} == 3'b000, "reset_ctrl", {psel, penable, pwrite}, 0);
        chk({paddr, pwdata} == 64'd0, "reset_addr_data", {paddr, pwdata}, 0);
        chk({req_rdata, req_done, req_err} == 36'd0, "reset_req_outputs", {req_rdata, req_done, req_err}, 0);
        presetn = 1'b1;
        @(negedge pclk);

        pend0.push_back(mk(1, 32'd3, 32'hDEADBEEF, 0, 0, 32'h0));
        run_batch();
        pend1.push_back(mk(0, 32'd2, 32'h0, 3, 0, 32'h12345678));
        run_batch();
        pend0.push_back(mk(0, 32'h40, 32'h1, 1, 1, 32'hCAFE0001));
        run_batch();
        pend1.push_back(mk(0, 32'h44, 32'h2, TIMEOUT, 0, 32'hBAD0BAD0));
        run_batch();
        pend0.push_back(mk(0, 32'h48, 32'h3, TIMEOUT - 1, 0, 32'h0000BEEF));
        run_batch();
        pend1.push_back(mk(1, 32'h4C, 32'h4, 2, 0, 32'hFFFFFFFF));
        run_batch();

        for (int b = 0; b < 40; b++) begin
            int n0, n1;
            n0 = $urandom_range(0, 3);
            n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
            for (int i = 0; i < n0; i++) pend0.push_back(rnd());
            for (int i = 0; i < n1; i++) pend1.push_back(rnd());
            run_batch();
        end

        pend0.push_back(mk(0, 32'h55, 32'h0, 6, 0, 32'h77777777));
        build_expected();
        @(negedge pclk);
        present();
        w = 0;
        do begin
            @(negedge pclk);
            w++;
        end while (!(psel && penable) && w < 20);
        chk(psel && penable, "reach_access", {psel, penable}, 2'b11);
        @(negedge pclk);
        #2;
        presetn = 1'b0;
        req_valid = '0;
        #1;
        chk({psel, penable} == 2'b00, "reset_async_drop", {psel, penable}, 0);
        pend0.delete(); pend1.delete(); exp_q.delete(); plan_q.delete();
        last_m = 1'b1;
        rdata_m = '0;
        @(negedge pclk);
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk({req_done, psel} == 3'b000, "reset_no_done", {req_done, psel}, 0);
        end
        chk(req_rdata == 32'd0, "reset_rdata", req_rdata, 0);

        for (int i = 0; i < 2; i++) begin
            pend0.push_back(mk(1'(i), 32'h100 + i, $urandom, 0, 0, $urandom));
            pend1.push_back(mk(1'(1 - i), 32'h200 + i, $urandom, 0, 0, $urandom));
        end
        run_batch();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
